// File: rtl/puf_key_pkg.sv
// Shared types and defaults for the PUF key deserialiser.
// Optional build macro used by the top: PUF_MAJORITY_VOTE_EN.
package puf_key_pkg;

   localparam int unsigned KEY_W_DEF     = 16;
   localparam int unsigned BYTE_W_DEF    = 8;
   localparam int unsigned GAP_MAX_DEF   = 32;
   localparam int unsigned NUM_READS_DEF = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DONE    = 2'd2,
      ABORT   = 2'd3
   } state_t;

   // Number of BYTE_W lanes that make up one key.
   function automatic int unsigned lanes_per_key(input int unsigned key_w,
                                                 input int unsigned byte_w);
      return key_w / byte_w;
   endfunction

   // Lane index width, never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

endpackage

// File: rtl/puf_majority_vote.sv
// Bitwise majority and disagreement mask over NUM stored key words.
// Purely combinational; NUM is odd and at most 7.
module puf_majority_vote #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NUM   = 3
) (
   input  logic [NUM-1:0][WIDTH-1:0] words,
   output logic [WIDTH-1:0]          majority,
   output logic [WIDTH-1:0]          unstable
);

   localparam logic [3:0] HALF = 4'(NUM / 2);
   localparam logic [3:0] ALL  = 4'(NUM);

   // Number of words that have bit b set.
   function automatic logic [3:0] ones_at(input logic [NUM-1:0][WIDTH-1:0] w,
                                          input int unsigned b);
      logic [3:0] c;
      c = '0;
      for (int unsigned r = 0; r < NUM; r++) begin
         c = c + 4'(w[r][b]);
      end
      return c;
   endfunction

   // Per-bit vote: set when more than half agree on 1, unstable unless unanimous.
   always_comb begin
      majority = '0;
      unstable = '0;
      for (int unsigned b = 0; b < WIDTH; b++) begin
         majority[b] = (ones_at(words, b) > HALF);
         unstable[b] = (ones_at(words, b) != 4'd0) && (ones_at(words, b) != ALL);
      end
   end

endmodule

// File: rtl/puf_key_deser.sv
// Reassembles a KEY_W-bit PUF key from BYTE_W-wide lanes, low lane first.
// Pulses KeyValid on completion and Timeout when a lane gap reaches GAP_MAX.
// Build macro PUF_MAJORITY_VOTE_EN: capture NUM_READS keys per Start and
// output their bitwise majority plus a disagreement mask on Unstable.
module puf_key_deser
   import puf_key_pkg::*;
#(
   parameter int unsigned KEY_W     = KEY_W_DEF,
   parameter int unsigned BYTE_W    = BYTE_W_DEF,
   parameter int unsigned GAP_MAX   = GAP_MAX_DEF,
   parameter int unsigned NUM_READS = NUM_READS_DEF
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Start,
   input  logic [BYTE_W-1:0] ByteIn,
   input  logic              ByteValid,
   output logic [KEY_W-1:0]  Key,
   output logic              KeyValid,
   output logic              Busy,
   output logic              Timeout,
   output logic [KEY_W-1:0]  Unstable
);

   localparam int unsigned      LANES    = lanes_per_key(KEY_W, BYTE_W);
   localparam int unsigned      IDX_W    = idx_width(LANES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);
   localparam logic [7:0]       GAP_LIM  = 8'(GAP_MAX);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [7:0]         gap_q, gap_d;
   logic [KEY_W-1:0]   partial_q, partial_d;
   logic [KEY_W-1:0]   key_q, key_d;
   logic               key_valid_q, key_valid_d;
   logic               busy_q, busy_d;
   logic               timeout_q, timeout_d;
   logic [KEY_W-1:0]   lane_word;
   logic               commit;

`ifdef PUF_MAJORITY_VOTE_EN
   localparam logic [2:0] LAST_READ = 3'(NUM_READS - 1);

   logic [2:0]                      reads_q, reads_d;
   logic [NUM_READS-1:0][KEY_W-1:0] vote_q, vote_d;
   logic [KEY_W-1:0]                unstable_q, unstable_d;
   logic [KEY_W-1:0]                maj_word, maj_mask;

   puf_majority_vote #(
      .WIDTH (KEY_W),
      .NUM   (NUM_READS)
   ) u_vote (
      .words    (vote_d),
      .majority (maj_word),
      .unstable (maj_mask)
   );
`endif

   // Capture FSM next state: Start restarts from any state and overrides
   // ByteValid, so it is handled once ahead of the per-state decode.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      gap_d     = gap_q;
      partial_d = partial_q;
      commit    = 1'b0;
      lane_word = partial_q;
      lane_word[int'(idx_q) * BYTE_W +: BYTE_W] = ByteIn;
`ifdef PUF_MAJORITY_VOTE_EN
      reads_d   = reads_q;
      vote_d    = vote_q;
`endif
      if (Start) begin
         state_d   = COLLECT;
         idx_d     = '0;
         gap_d     = '0;
         partial_d = '0;
`ifdef PUF_MAJORITY_VOTE_EN
         reads_d   = '0;
`endif
      end else begin
         case (state_q)
            IDLE: state_d = IDLE;
            COLLECT: begin
               if (ByteValid) begin
                  partial_d = lane_word;
                  gap_d     = '0;
                  if (idx_q == LAST_IDX) begin
                     idx_d = '0;
`ifdef PUF_MAJORITY_VOTE_EN
                     for (int unsigned r = 0; r < NUM_READS; r++) begin
                        if (reads_q == 3'(r)) begin
                           vote_d[r] = lane_word;
                        end
                     end
                     if (reads_q == LAST_READ) begin
                        reads_d = '0;
                        state_d = DONE;
                        commit  = 1'b1;
                     end else begin
                        reads_d = reads_q + 3'd1;
                     end
`else
                     state_d = DONE;
                     commit  = 1'b1;
`endif
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end else begin
                  gap_d = (gap_q == 8'hFF) ? gap_q : gap_q + 8'd1;
                  if (gap_d >= GAP_LIM) begin
                     state_d = ABORT;
                  end
               end
            end
            DONE: state_d = IDLE;
            ABORT: begin
               partial_d = '0;
               state_d   = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Registered outputs derived from the state being entered.
   always_comb begin
      key_d       = key_q;
      key_valid_d = commit;
      busy_d      = (state_d == COLLECT);
      timeout_d   = (state_d == ABORT);
`ifdef PUF_MAJORITY_VOTE_EN
      unstable_d  = unstable_q;
      if (commit) begin
         key_d      = maj_word;
         unstable_d = maj_mask;
      end
`else
      if (commit) begin
         key_d = lane_word;
      end
`endif
   end

   // State, counters, partial buffer and output registers.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         gap_q       <= '0;
         partial_q   <= '0;
         key_q       <= '0;
         key_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         gap_q       <= gap_d;
         partial_q   <= partial_d;
         key_q       <= key_d;
         key_valid_q <= key_valid_d;
         busy_q      <= busy_d;
         timeout_q   <= timeout_d;
      end
   end

`ifdef PUF_MAJORITY_VOTE_EN
   // Read counter, vote buffer and disagreement mask.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         reads_q    <= '0;
         vote_q     <= '0;
         unstable_q <= '0;
      end else begin
         reads_q    <= reads_d;
         vote_q     <= vote_d;
         unstable_q <= unstable_d;
      end
   end

   assign Unstable = unstable_q;
`else
   assign Unstable = '0;
`endif

   assign Key      = key_q;
   assign KeyValid = key_valid_q;
   assign Busy     = busy_q;
   assign Timeout  = timeout_q;

endmodule

// File: tb/tb_puf_key_deser.sv
// Directed bench for puf_key_deser (KEY_W=16, BYTE_W=8, GAP_MAX=32).
// With PUF_MAJORITY_VOTE_EN defined it runs the three-read vote sequence.
module tb_puf_key_deser;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic [15:0] key;
   logic        key_valid;
   logic        busy;
   logic        timeout;
   logic [15:0] unstable;

   int unsigned tests;
   int unsigned fails;

   puf_key_deser #(
      .KEY_W     (16),
      .BYTE_W    (8),
      .GAP_MAX   (32),
      .NUM_READS (3)
   ) dut (
      .Clk       (clk),
      .Rst       (rst),
      .Start     (start),
      .ByteIn    (byte_in),
      .ByteValid (byte_valid),
      .Key       (key),
      .KeyValid  (key_valid),
      .Busy      (busy),
      .Timeout   (timeout),
      .Unstable  (unstable)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        start;
      logic        bv;
      logic [7:0]  din;
      int unsigned pre_idle;
      logic [15:0] key;
      logic        kv;
      logic        busy;
      logic        to;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, return just after the rising edge.
   task automatic step(input logic r, input logic s, input logic v, input logic [7:0] d);
      @(negedge clk);
      rst        = r;
      start      = s;
      byte_valid = v;
      byte_in    = d;
      @(posedge clk);
      #1;
   endtask

   task automatic check_outputs(input string tag, input logic [15:0] ek, input logic ekv,
                                input logic eb, input logic eto, input logic [15:0] eu);
      check({tag, " key"},      32'(key),       32'(ek));
      check({tag, " keyvalid"}, 32'(key_valid), 32'(ekv));
      check({tag, " busy"},     32'(busy),      32'(eb));
      check({tag, " timeout"},  32'(timeout),   32'(eto));
      check({tag, " unstable"}, 32'(unstable),  32'(eu));
   endtask

`ifndef PUF_MAJORITY_VOTE_EN
   vec_t vecs [27];
   int unsigned to_pulses;
   int unsigned to_first;
`endif

   initial begin
      tests      = 0;
      fails      = 0;
      rst        = 1'b0;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_in    = 8'h00;

`ifndef PUF_MAJORITY_VOTE_EN
      //          rst   start bv    din    pre key       kv    busy  to
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 0,  16'h0000, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 0,  16'h0000, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'hAA, 0,  16'h0000, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h55, 19, 16'h55AA, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 0,  16'h55AA, 1'b0, 1'b0, 1'b0};
      // restart inside COLLECT, Start beats ByteValid
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 0,  16'h55AA, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h34, 0,  16'h55AA, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 1'b1, 8'hFF, 0,  16'h55AA, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h78, 0,  16'h55AA, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h56, 0,  16'h5678, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 0,  16'h5678, 1'b0, 1'b0, 1'b0};
      // Start with ByteValid in IDLE discards the byte
      vecs[11] = '{1'b0, 1'b1, 1'b1, 8'h77, 0,  16'h5678, 1'b0, 1'b1, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 1'b1, 8'h01, 0,  16'h5678, 1'b0, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 1'b1, 8'h02, 0,  16'h0201, 1'b1, 1'b0, 1'b0};
      // Start while in DONE goes straight back to COLLECT
      vecs[14] = '{1'b0, 1'b1, 1'b1, 8'hEE, 0,  16'h0201, 1'b0, 1'b1, 1'b0};
      vecs[15] = '{1'b0, 1'b0, 1'b1, 8'hA1, 0,  16'h0201, 1'b0, 1'b1, 1'b0};
      vecs[16] = '{1'b0, 1'b0, 1'b1, 8'hB2, 0,  16'hB2A1, 1'b1, 1'b0, 1'b0};
      // ByteValid in IDLE without Start is ignored
      vecs[17] = '{1'b0, 1'b0, 1'b1, 8'h3C, 0,  16'hB2A1, 1'b0, 1'b0, 1'b0};
      vecs[18] = '{1'b0, 1'b0, 1'b1, 8'hC3, 0,  16'hB2A1, 1'b0, 1'b0, 1'b0};
      // reset between first and second lane
      vecs[19] = '{1'b0, 1'b1, 1'b0, 8'h00, 0,  16'hB2A1, 1'b0, 1'b1, 1'b0};
      vecs[20] = '{1'b0, 1'b0, 1'b1, 8'h11, 0,  16'hB2A1, 1'b0, 1'b1, 1'b0};
      vecs[21] = '{1'b1, 1'b0, 1'b0, 8'h00, 0,  16'h0000, 1'b0, 1'b0, 1'b0};
      vecs[22] = '{1'b0, 1'b0, 1'b1, 8'h99, 0,  16'h0000, 1'b0, 1'b0, 1'b0};
      vecs[23] = '{1'b0, 1'b0, 1'b1, 8'h99, 2,  16'h0000, 1'b0, 1'b0, 1'b0};
      // reload 16'h55AA ahead of the timeout sequence
      vecs[24] = '{1'b0, 1'b1, 1'b0, 8'h00, 0,  16'h0000, 1'b0, 1'b1, 1'b0};
      vecs[25] = '{1'b0, 1'b0, 1'b1, 8'hAA, 0,  16'h0000, 1'b0, 1'b1, 1'b0};
      vecs[26] = '{1'b0, 1'b0, 1'b1, 8'h55, 19, 16'h55AA, 1'b1, 1'b0, 1'b0};

      for (int i = 0; i < 27; i++) begin
         for (int unsigned k = 0; k < vecs[i].pre_idle; k++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00);
         end
         step(vecs[i].rst, vecs[i].start, vecs[i].bv, vecs[i].din);
         check_outputs($sformatf("v%0d", i), vecs[i].key, vecs[i].kv,
                       vecs[i].busy, vecs[i].to, 16'h0000);
      end

      // Gap timeout: one lane then 32 idle cycles aborts; Key is kept.
      step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b1, 8'h12);
      check_outputs("to_lane", 16'h55AA, 1'b0, 1'b1, 1'b0, 16'h0000);
      to_pulses = 0;
      to_first  = 0;
      for (int unsigned c = 1; c <= 40; c++) begin
         step(1'b0, 1'b0, 1'b0, 8'h00);
         if (timeout === 1'b1) begin
            to_pulses++;
            if (to_first == 0) to_first = c;
         end
         if (c == 31) check_outputs("to_c31", 16'h55AA, 1'b0, 1'b1, 1'b0, 16'h0000);
         if (c == 32) check_outputs("to_c32", 16'h55AA, 1'b0, 1'b0, 1'b1, 16'h0000);
         if (c == 33) check_outputs("to_c33", 16'h55AA, 1'b0, 1'b0, 1'b0, 16'h0000);
      end
      check("to_pulse_count", 32'(to_pulses), 32'd1);
      check("to_pulse_cycle", 32'(to_first),  32'd32);
`else
      // Three reads 16'h5555, 16'h5554, 16'h5555 -> majority 16'h5555, bit 0 unstable.
      step(1'b1, 1'b0, 1'b0, 8'h00);
      check_outputs("mv_rst", 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      check_outputs("mv_start", 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000);
      begin
         logic [7:0] lanes [6];
         lanes = '{8'h55, 8'h55, 8'h54, 8'h55, 8'h55, 8'h55};
         for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, lanes[i]);
            check_outputs($sformatf("mv_lane%0d", i), 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000);
         end
         step(1'b0, 1'b0, 1'b1, lanes[5]);
         check_outputs("mv_done", 16'h5555, 1'b1, 1'b0, 1'b0, 16'h0001);
      end
      step(1'b0, 1'b0, 1'b0, 8'h00);
      check_outputs("mv_after", 16'h5555, 1'b0, 1'b0, 1'b0, 16'h0001);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      check_outputs("mv_hold", 16'h5555, 1'b0, 1'b0, 1'b0, 16'h0001);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
